// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_driver
//  Description : Four-digit common-anode seven-segment scan driver. A 16-bit
//                value and per-digit decimal points are captured into a shadow
//                register on load_i. A refresh divider steps the scanned digit
//                index. A registered output stage decodes the selected nibble
//                and applies per-digit blanking and leading-zero suppression.
//                It also applies output polarity.
//  Ports       : clk            - system clock
//                rst            - synchronous reset, active low
//                value_i[15:0]  - display data, [3:0] = digit0 (rightmost)
//                load_i         - capture strobe for value_i / dp_i
//                dp_i[3:0]      - decimal point request per digit
//                blank_i[3:0]   - forced blank per digit (live, not shadowed)
//                lz_suppress_i  - leading-zero blanking enable (live)
//                an_o[3:0]      - anode enables, bit i = digit i
//                seg_o[6:0]     - segments, bit0 = a ... bit6 = g
//                dp_out_o       - decimal point segment
//                digit_tick_o   - one-cycle pulse when the scan index advances
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_driver #(
  parameter int REFRESH_DIV    = 100000,
  parameter int DIV_WIDTH      = 17,
  parameter bit ACTIVE_LOW_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_i,
  input  logic        load_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  blank_i,
  input  logic        lz_suppress_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_out_o,
  output logic        digit_tick_o
);

  localparam logic [DIV_WIDTH-1:0] c_div_last = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] c_div_one  = DIV_WIDTH'(1);

  // Idle (all-off) levels at the pins for the selected polarity.
  localparam logic [3:0] c_an_idle  = {4{ACTIVE_LOW_OUT}};
  localparam logic [6:0] c_seg_idle = {7{ACTIVE_LOW_OUT}};
  localparam logic       c_dp_idle  = ACTIVE_LOW_OUT;

  logic [DIV_WIDTH-1:0] div_cnt_q,    div_cnt_d;
  logic [1:0]           digit_idx_q,  digit_idx_d;
  logic                 tick_q,       tick_d;
  logic [15:0]          shadow_val_q, shadow_val_d;
  logic [3:0]           shadow_dp_q,  shadow_dp_d;
  logic [3:0]           an_q,         an_d;
  logic [6:0]           seg_q,        seg_d;
  logic                 dp_q,         dp_d;

  logic [3:0] w_nibble;
  logic [6:0] w_seg_hi;
  logic [3:0] w_lz_zero;
  logic       w_blank;

  // Divider, scan index and shadow capture.
  always_comb begin
    div_cnt_d    = div_cnt_q + c_div_one;
    digit_idx_d  = digit_idx_q;
    tick_d       = 1'b0;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (div_cnt_q == c_div_last) begin
      div_cnt_d   = '0;
      digit_idx_d = digit_idx_q + 2'd1;
      tick_d      = 1'b1;
    end
    if (load_i) begin
      shadow_val_d = value_i;
      shadow_dp_d  = dp_i;
    end
  end

  // Nibble select for the digit currently indexed.
  always_comb begin
    w_nibble = shadow_val_q[3:0];
    case (digit_idx_q)
      2'd0: w_nibble = shadow_val_q[3:0];
      2'd1: w_nibble = shadow_val_q[7:4];
      2'd2: w_nibble = shadow_val_q[11:8];
      2'd3: w_nibble = shadow_val_q[15:12];
      default: w_nibble = shadow_val_q[3:0];
    endcase
  end

  // Hex to active-high gfedcba.
  always_comb begin
    w_seg_hi = 7'h00;
    case (w_nibble)
      4'h0: w_seg_hi = 7'h3F;
      4'h1: w_seg_hi = 7'h06;
      4'h2: w_seg_hi = 7'h5B;
      4'h3: w_seg_hi = 7'h4F;
      4'h4: w_seg_hi = 7'h66;
      4'h5: w_seg_hi = 7'h6D;
      4'h6: w_seg_hi = 7'h7D;
      4'h7: w_seg_hi = 7'h07;
      4'h8: w_seg_hi = 7'h7F;
      4'h9: w_seg_hi = 7'h6F;
      4'hA: w_seg_hi = 7'h77;
      4'hB: w_seg_hi = 7'h7C;
      4'hC: w_seg_hi = 7'h39;
      4'hD: w_seg_hi = 7'h5E;
      4'hE: w_seg_hi = 7'h79;
      4'hF: w_seg_hi = 7'h71;
      default: w_seg_hi = 7'h00;
    endcase
  end

  // A digit is a leading zero when it and every higher nibble are zero.
  // Digit0 is never suppressed, so a value of zero still shows "0".
  assign w_lz_zero[3] = (shadow_val_q[15:12] == 4'h0);
  assign w_lz_zero[2] = (shadow_val_q[11:8]  == 4'h0) & w_lz_zero[3];
  assign w_lz_zero[1] = (shadow_val_q[7:4]   == 4'h0) & w_lz_zero[2];
  assign w_lz_zero[0] = 1'b0;

  assign w_blank = blank_i[digit_idx_q] | (lz_suppress_i & w_lz_zero[digit_idx_q]);

  // Output stage: build active-high values, then apply pin polarity last.
  always_comb begin
    an_d  = 4'b0001 << digit_idx_q;
    seg_d = w_seg_hi;
    dp_d  = shadow_dp_q[digit_idx_q];
    if (w_blank) begin
      an_d  = 4'b0000;
      seg_d = 7'h00;
      dp_d  = 1'b0;
    end
    an_d  = an_d  ^ c_an_idle;
    seg_d = seg_d ^ c_seg_idle;
    dp_d  = dp_d  ^ c_dp_idle;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q    <= '0;
      digit_idx_q  <= 2'd0;
      tick_q       <= 1'b0;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'b0000;
      an_q         <= c_an_idle;
      seg_q        <= c_seg_idle;
      dp_q         <= c_dp_idle;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_idx_q  <= digit_idx_d;
      tick_q       <= tick_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_out_o     = dp_q;
  assign digit_tick_o = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_scan_driver
//  Description : Directed scoreboard bench. Stimulus pushes hand-computed
//                per-edge expectations into a queue. A negedge monitor pops
//                and compares them against two instances (REFRESH_DIV=4 and
//                REFRESH_DIV=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz;

  logic [3:0] an4, an1;
  logic [6:0] seg4, seg1;
  logic       dpo4, dpo1, tick4, tick1;

  always #5 clk = ~clk;

  sseg_scan_driver #(.REFRESH_DIV(4), .DIV_WIDTH(3), .ACTIVE_LOW_OUT(1'b1)) dut4 (
    .clk(clk), .rst(rst), .value_i(value), .load_i(load), .dp_i(dp),
    .blank_i(blank), .lz_suppress_i(lz), .an_o(an4), .seg_o(seg4),
    .dp_out_o(dpo4), .digit_tick_o(tick4));

  sseg_scan_driver #(.REFRESH_DIV(1), .DIV_WIDTH(1), .ACTIVE_LOW_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .value_i(value), .load_i(load), .dp_i(dp),
    .blank_i(blank), .lz_suppress_i(lz), .an_o(an1), .seg_o(seg1),
    .dp_out_o(dpo1), .digit_tick_o(tick1));

  typedef struct {
    int         cyc;
    bit         which1;
    int         ph;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ph = 0;
  int   base = 0;

  // Per-digit expected pin values for the current display content.
  logic [3:0] t_an  [4];
  logic [6:0] t_seg [4];
  logic       t_dp  [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this edge.
  always @(negedge clk) begin
    exp_t e;
    logic [12:0] got, want;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      got  = e.which1 ? {an1, seg1, dpo1, tick1} : {an4, seg4, dpo4, tick4};
      want = {e.an, e.seg, e.dp, e.tick};
      if (e.cyc != cyc || got !== want) begin
        failures++;
        $display("FAIL phase%0d dut%0d edge=%0d(now %0d) got an=%b seg=%h dp=%b tick=%b exp an=%b seg=%h dp=%b tick=%b",
                 e.ph, e.which1 ? 1 : 4, e.cyc, cyc, got[12:9], got[8:2], got[1], got[0],
                 e.an, e.seg, e.dp, e.tick);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input bit w, input logic [3:0] a,
                      input logic [6:0] s, input logic d, input logic t);
    exp_t e;
    e.cyc = c; e.which1 = w; e.ph = ph;
    e.an = a; e.seg = s; e.dp = d; e.tick = t;
    q.push_back(e);
  endtask

  task automatic set_tab(input int d, input logic [3:0] a, input logic [6:0] s, input logic p);
    t_an[d] = a; t_seg[d] = s; t_dp[d] = p;
  endtask

  // Expectations for edges first..last using the scan phase anchored at base.
  task automatic push_scan(input int first, input int last, input bit chk1);
    for (int e = first; e <= last; e++) begin
      int d4, d1;
      d4 = ((e - base) / 4) % 4;
      push(e, 1'b0, t_an[d4], t_seg[d4], t_dp[d4], ((e - base) % 4) == 3);
      if (chk1) begin
        d1 = (e - base) % 4;
        push(e, 1'b1, t_an[d1], t_seg[d1], t_dp[d1], 1'b1);
      end
    end
  endtask

  task automatic run_load(input logic [15:0] v, input logic [3:0] d, input int n, input bit chk1);
    value = v; dp = d; load = 1'b1;
    step(1);
    load = 1'b0;
    push_scan(cyc + 1, cyc + n, chk1);
    step(n);
  endtask

  initial begin
    // 1: reset with load asserted must keep everything idle.
    ph = 1;
    rst = 1'b0; load = 1'b1; value = 16'hFFFF; dp = 4'b0000; blank = 4'b0000; lz = 1'b0;
    for (int e = 1; e <= 3; e++) push(e, 1'b0, 4'b1111, 7'h7F, 1'b1, 1'b0);
    step(3);

    // 2: release with a capture of 12AF; first edge shows the reset shadow "0".
    ph = 2;
    rst = 1'b1; value = 16'h12AF;
    base = cyc + 1;
    push(cyc + 1, 1'b0, 4'b1110, 7'h40, 1'b1, 1'b0);
    step(1);
    load = 1'b0;
    set_tab(0, 4'b1110, 7'h0E, 1'b1);
    set_tab(1, 4'b1101, 7'h08, 1'b1);
    set_tab(2, 4'b1011, 7'h24, 1'b1);
    set_tab(3, 4'b0111, 7'h79, 1'b1);
    push_scan(cyc + 1, cyc + 16, 1'b0);
    step(16);

    // 3: leading-zero suppression.
    ph = 3;
    lz = 1'b1;
    set_tab(0, 4'b1110, 7'h12, 1'b1);
    set_tab(1, 4'b1111, 7'h7F, 1'b1);
    set_tab(2, 4'b1111, 7'h7F, 1'b1);
    set_tab(3, 4'b1111, 7'h7F, 1'b1);
    run_load(16'h0005, 4'b0000, 16, 1'b0);
    set_tab(0, 4'b1110, 7'h40, 1'b1);
    run_load(16'h0000, 4'b0000, 16, 1'b0);
    set_tab(0, 4'b1110, 7'h40, 1'b1);
    set_tab(1, 4'b1101, 7'h40, 1'b1);
    set_tab(2, 4'b1011, 7'h12, 1'b1);
    set_tab(3, 4'b1111, 7'h7F, 1'b1);
    run_load(16'h0500, 4'b0000, 16, 1'b0);

    // 4: value change without load is invisible; mid-slot load shows next edge.
    ph = 4;
    value = 16'h3333;
    push_scan(cyc + 1, cyc + 8, 1'b0);
    step(8);
    while (((cyc + 1 - base) % 4) != 1) step(1);
    push_scan(cyc + 1, cyc + 1, 1'b0);
    set_tab(0, 4'b1110, 7'h30, 1'b1);
    set_tab(1, 4'b1101, 7'h30, 1'b1);
    set_tab(2, 4'b1011, 7'h30, 1'b1);
    set_tab(3, 4'b0111, 7'h30, 1'b1);
    run_load(16'h3333, 4'b0000, 8, 1'b0);

    // 5: reset while digit 2 is on the pins.
    ph = 5;
    while (((cyc - base) / 4) % 4 != 2) step(1);
    rst = 1'b0; lz = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      push(cyc + k, 1'b0, 4'b1111, 7'h7F, 1'b1, 1'b0);
      push(cyc + k, 1'b1, 4'b1111, 7'h7F, 1'b1, 1'b0);
    end
    step(2);
    rst = 1'b1;
    base = cyc + 1;
    set_tab(0, 4'b1110, 7'h40, 1'b1);
    set_tab(1, 4'b1101, 7'h40, 1'b1);
    set_tab(2, 4'b1011, 7'h40, 1'b1);
    set_tab(3, 4'b0111, 7'h40, 1'b1);
    push_scan(cyc + 1, cyc + 16, 1'b1);
    step(16);

    // 6: decimal point on digit2, forced blank on digit3, both scan rates.
    ph = 6;
    blank = 4'b1000;
    set_tab(0, 4'b1110, 7'h00, 1'b1);
    set_tab(1, 4'b1101, 7'h00, 1'b1);
    set_tab(2, 4'b1011, 7'h00, 1'b0);
    set_tab(3, 4'b1111, 7'h7F, 1'b1);
    run_load(16'h8888, 4'b0100, 16, 1'b1);

    step(2);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations never compared, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
